seq_mult_ctrl: RTL
==================

# seq_mult_ctrl

Sequential shift-add multiplier controller for the 5x5 partial-product datapath. Accepts one operand pair per start/done handshake, then sequences generation and accumulation of one partial product per clock into a 2*WIDTH-bit accumulator. Presents a registered product with a one-cycle done pulse. Sits between the requesting logic and the array-multiplier lab datapath, replacing the combinational five-row sum with a time-multiplexed adder.

## Interface
- WIDTH, 5, operand width; product is 2*WIDTH bits; step counter is clog2(WIDTH) bits
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  multiplicand; latched when start is accepted
- b  input  WIDTH  multiplier; latched when start is accepted
- busy  output  1  high while in ACC
- done  output  1  single-cycle pulse; product valid
- product  output  2*WIDTH  result register; holds until the next accepted start

## Operation
- States: IDLE, ACC, DONE. Reset state is IDLE.
- Outputs after reset: busy=0, done=0, product=0, accumulator=0, step=0.
- IDLE:
  - start=1 at an edge latches a->A and b->B, clears the accumulator, sets step=0, and moves to ACC.
  - start=0 stays in IDLE.
- ACC, one step per edge, step i = 0..WIDTH-1:
  - Partial product pp_i = (A & {WIDTH{B[i]}}) extended to 2*WIDTH bits, shifted left by i.
  - For i < WIDTH-1: acc <= acc + pp_i.
  - For i = WIDTH-1: acc <= acc + pp_i unsigned, or acc - pp_i signed (see Configuration).
  - After the i = WIDTH-1 step: product <= final acc, go to DONE.
  - The final step writes product directly from the adder output.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
- Arithmetic is modulo 2^(2*WIDTH) with no overflow flag. A 2*WIDTH-bit result is always exact for both signed and unsigned operands.
- start while busy or in DONE: ignored. a/b changes after acceptance have no effect.
- start held high continuously: a new operation is accepted on the first IDLE edge after DONE, giving a throughput of one result per WIDTH+2 cycles.
- rst mid-operation: the next edge returns to IDLE with all outputs at their reset values. The in-flight result is discarded and no done pulse is issued.

## Timing
- Start accepted at edge E0 (start=1 while IDLE).
- busy=1 from after E0 until after E(WIDTH); with WIDTH=5 that is 5 cycles.
- product updates and done rises after edge E(WIDTH); done falls after E(WIDTH+1).
- Start-to-done latency is WIDTH cycles (5 at default).
- Earliest next accept is at edge E(WIDTH+2).
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SEQ_MULT_SIGNED_EN defined:
  - a and b are two's complement.
  - pp_i uses a sign-extended A.
  - The step for bit WIDTH-1 subtracts pp_i, giving Baugh-Wooley weighting -2^(WIDTH-1).
  - product is a two's-complement result.
- SEQ_MULT_SIGNED_EN undefined:
  - Operands are unsigned and pp_i uses a zero-extended A.
  - All WIDTH steps add.
  - product is an unsigned result.
- State machine, latency and handshake are identical in both builds.

## Test plan
- Signed build, a=5'h07, b=5'h1D (7 x -3), one start pulse: busy high 5 cycles, then done one cycle with product=10'h3EB (-21).
- Signed build, a=5'h10, b=5'h10 (-16 x -16) -> product=10'h100 (256). Then a=5'h10, b=5'h0F (-16 x 15) -> product=10'h310 (-240).
- Unsigned build, a=5'h1F, b=5'h1F -> product=10'h3C1 (961). Then a=0, b=5'h1F -> product=10'h000.
- start held high for 20 cycles with fixed a=3, b=4: done pulses every 7 cycles, product=10'h00C each time. a/b changed mid-ACC does not alter the result.
- rst asserted in the third ACC cycle: the next cycle shows busy=0, done=0, product=0. No done pulse follows; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add multiplier: one partial product per clock into a 2*WIDTH-bit accumulator.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands (Baugh-Wooley final subtract).
module seq_mult_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [PW-1:0]    acc_r;
  logic [SW-1:0]    step_r;
  logic             busy_r;
  logic             done_r;
  logic [PW-1:0]    product_r;

  logic [PW-1:0]    a_ext_s;
  logic [PW-1:0]    pp_s;
  logic             last_s;
  logic [PW-1:0]    sum_s;

  // Partial product for multiplier bit idx: extended multiplicand gated by that bit, weighted by 2^idx.
  function automatic logic [PW-1:0] partial_product(input logic [PW-1:0] mcand,
                                                    input logic [WIDTH-1:0] mplier,
                                                    input logic [SW-1:0] idx);
    logic [PW-1:0] pp;
    if (mplier[idx]) begin
      pp = mcand << idx;
    end else begin
      pp = {PW{1'b0}};
    end
    return pp;
  endfunction

  // Step datapath: extend A, form pp_i, add (or subtract on the sign-weighted last step).
  always_comb begin
    a_ext_s = {PW{1'b0}};
    pp_s    = {PW{1'b0}};
    last_s  = 1'b0;
    sum_s   = {PW{1'b0}};
`ifdef SEQ_MULT_SIGNED_EN
    a_ext_s = {{WIDTH{a_r[WIDTH-1]}}, a_r};
`else
    a_ext_s = {{WIDTH{1'b0}}, a_r};
`endif
    pp_s   = partial_product(a_ext_s, b_r, step_r);
    last_s = (step_r == SW'(WIDTH - 1));
`ifdef SEQ_MULT_SIGNED_EN
    if (last_s) begin
      sum_s = acc_r - pp_s;
    end else begin
      sum_s = acc_r + pp_s;
    end
`else
    sum_s = acc_r + pp_s;
`endif
  end

  // Control FSM and all output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      acc_r     <= {PW{1'b0}};
      step_r    <= {SW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= {PW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            acc_r   <= {PW{1'b0}};
            step_r  <= {SW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ST_ACC;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_ACC: begin
          acc_r <= sum_s;
          if (last_s) begin
            product_r <= sum_s;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            step_r    <= step_r + SW'(1);
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule
